// File: rtl/fir_mac_seq.sv
// fir_mac_seq: time-multiplexed FIR multiply-accumulate stage.
// On each accepted VIN it snapshots the TAPS tap values and runs one
// signed MAC per cycle against a programmable coefficient bank. The sum
// is then rounded half-up, arithmetically shifted right by SHIFT and
// presented on DOUT with a one-cycle VOUT pulse.
// Optional feature macro: FIR_MAC_SAT_EN
//   defined   -> the result saturates to the OUT_WIDTH range and OVF sets on clip
//   undefined -> the result wraps to its low OUT_WIDTH bits and OVF stays 0
`default_nettype none

module fir_mac_seq #(
    parameter int DATA_WIDTH = 13,
    parameter int COEF_WIDTH = 13,
    parameter int TAPS       = 8,
    parameter int ACC_WIDTH  = DATA_WIDTH + COEF_WIDTH + $clog2(TAPS),
    parameter int SHIFT      = 12,
    parameter int OUT_WIDTH  = 16
) (
    input  logic                         CLK,
    input  logic                         RST_n,
    input  logic                         VIN,
    input  logic signed [DATA_WIDTH-1:0] tp [0:TAPS-1],
    input  logic                         COEF_WE,
    input  logic [$clog2(TAPS)-1:0]      COEF_ADDR,
    input  logic signed [COEF_WIDTH-1:0] COEF_DIN,
    output logic signed [OUT_WIDTH-1:0]  DOUT,
    output logic                         VOUT,
    output logic                         BUSY,
    output logic                         DROP,
    output logic                         OVF
);

    localparam int IDX_W  = $clog2(TAPS);
    localparam int PROD_W = DATA_WIDTH + COEF_WIDTH;
    localparam int RND_W  = ACC_WIDTH + 1;

    localparam logic [IDX_W-1:0]        IDX_LAST = IDX_W'(TAPS - 1);
    localparam logic [IDX_W:0]          TAPS_C   = (IDX_W + 1)'(TAPS);
    localparam logic signed [RND_W-1:0] RND_C    = {{(RND_W - 1){1'b0}}, 1'b1} <<< (SHIFT - 1);
`ifdef FIR_MAC_SAT_EN
    localparam logic signed [RND_W-1:0] SAT_MAX = {{(RND_W - OUT_WIDTH + 1){1'b0}}, {(OUT_WIDTH - 1){1'b1}}};
    localparam logic signed [RND_W-1:0] SAT_MIN = {{(RND_W - OUT_WIDTH + 1){1'b1}}, {(OUT_WIDTH - 1){1'b0}}};
    localparam logic signed [OUT_WIDTH-1:0] OUT_MAX = {1'b0, {(OUT_WIDTH - 1){1'b1}}};
    localparam logic signed [OUT_WIDTH-1:0] OUT_MIN = {1'b1, {(OUT_WIDTH - 1){1'b0}}};
`endif

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_CAPTURE = 2'd1,
        S_MAC     = 2'd2,
        S_ROUND   = 2'd3
    } state_t;

    state_t                        state_r;
    state_t                        state_nxt_s;
    logic                          idle_s;
    logic                          cap_s;
    logic                          mac_s;
    logic                          rnd_s;
    logic                          addr_ok_s;

    logic signed [DATA_WIDTH-1:0]  snap_r [0:TAPS-1];
    logic signed [COEF_WIDTH-1:0]  coef_r [0:TAPS-1];
    logic signed [ACC_WIDTH-1:0]   acc_r;
    logic [IDX_W-1:0]              idx_r;

    logic signed [PROD_W-1:0]      prod_s;
    logic signed [ACC_WIDTH-1:0]   prod_ext_s;
    logic signed [RND_W-1:0]       acc_ext_s;
    logic signed [RND_W-1:0]       rnd_sum_s;
    logic signed [RND_W-1:0]       shifted_s;
    logic signed [OUT_WIDTH-1:0]   res_s;
    logic                          clip_s;

    logic signed [OUT_WIDTH-1:0]   dout_r;
    logic                          vout_r;
    logic                          busy_r;
    logic                          drop_r;
    logic                          ovf_r;

    // FSM state register
    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next-state logic: one pass IDLE -> CAPTURE -> MAC x TAPS -> ROUND
    always_comb begin
        state_nxt_s = S_IDLE;
        case (state_r)
            S_IDLE: begin
                if (VIN) begin
                    state_nxt_s = S_CAPTURE;
                end else begin
                    state_nxt_s = S_IDLE;
                end
            end
            S_CAPTURE: state_nxt_s = S_MAC;
            S_MAC: begin
                if (idx_r == IDX_LAST) begin
                    state_nxt_s = S_ROUND;
                end else begin
                    state_nxt_s = S_MAC;
                end
            end
            S_ROUND:   state_nxt_s = S_IDLE;
            default:   state_nxt_s = S_IDLE;
        endcase
    end

    // FSM output decode: per-state datapath enables
    always_comb begin
        idle_s = 1'b0;
        cap_s  = 1'b0;
        mac_s  = 1'b0;
        rnd_s  = 1'b0;
        case (state_r)
            S_IDLE:    idle_s = 1'b1;
            S_CAPTURE: cap_s  = 1'b1;
            S_MAC:     mac_s  = 1'b1;
            S_ROUND:   rnd_s  = 1'b1;
            default: begin
                idle_s = 1'b0;
                cap_s  = 1'b0;
                mac_s  = 1'b0;
                rnd_s  = 1'b0;
            end
        endcase
    end

    // Datapath: current product, rounding, shift and range limiting
    always_comb begin
        addr_ok_s  = ({1'b0, COEF_ADDR} < TAPS_C);
        prod_s     = PROD_W'(snap_r[idx_r]) * PROD_W'(coef_r[idx_r]);
        prod_ext_s = {{(ACC_WIDTH - PROD_W){prod_s[PROD_W-1]}}, prod_s};
        acc_ext_s  = {acc_r[ACC_WIDTH-1], acc_r};
        rnd_sum_s  = acc_ext_s + RND_C;
        shifted_s  = rnd_sum_s >>> SHIFT;
`ifdef FIR_MAC_SAT_EN
        if (shifted_s > SAT_MAX) begin
            res_s  = OUT_MAX;
            clip_s = 1'b1;
        end else if (shifted_s < SAT_MIN) begin
            res_s  = OUT_MIN;
            clip_s = 1'b1;
        end else begin
            res_s  = OUT_WIDTH'(shifted_s);
            clip_s = 1'b0;
        end
`else
        res_s  = OUT_WIDTH'(shifted_s);
        clip_s = 1'b0;
`endif
    end

    // Busy flag follows the next state so it rises on the accepting edge
    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            busy_r <= 1'b0;
        end else begin
            busy_r <= (state_nxt_s != S_IDLE);
        end
    end

    // Tap snapshot, taken one edge after VIN so the delay line has shifted
    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            for (int i = 0; i < TAPS; i++) begin
                snap_r[i] <= '0;
            end
        end else if (cap_s) begin
            for (int i = 0; i < TAPS; i++) begin
                snap_r[i] <= tp[i];
            end
        end
    end

    // Coefficient bank: writable only while idle and only for valid indices
    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            for (int i = 0; i < TAPS; i++) begin
                coef_r[i] <= '0;
            end
        end else if (idle_s && COEF_WE && addr_ok_s) begin
            coef_r[COEF_ADDR] <= COEF_DIN;
        end
    end

    // Accumulator and tap index
    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            acc_r <= '0;
            idx_r <= '0;
        end else if (cap_s) begin
            acc_r <= '0;
            idx_r <= '0;
        end else if (mac_s) begin
            acc_r <= acc_r + prod_ext_s;
            idx_r <= idx_r + IDX_W'(1);
        end
    end

    // Output register: DOUT holds between results, VOUT pulses once
    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            dout_r <= '0;
            vout_r <= 1'b0;
        end else begin
            vout_r <= rnd_s;
            if (rnd_s) begin
                dout_r <= res_s;
            end
        end
    end

    // Sticky status: dropped samples and clipped results
    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            drop_r <= 1'b0;
            ovf_r  <= 1'b0;
        end else begin
            if (VIN && busy_r) begin
                drop_r <= 1'b1;
            end
            if (rnd_s && clip_s) begin
                ovf_r <= 1'b1;
            end
        end
    end

    assign DOUT = dout_r;
    assign VOUT = vout_r;
    assign BUSY = busy_r;
    assign DROP = drop_r;
    assign OVF  = ovf_r;

endmodule

`default_nettype wire

// File: tb/tb_fir_mac_seq.sv
// Directed bench for fir_mac_seq. Expected results are queued when a
// sample is launched and compared when VOUT is seen. A second instance
// with TAPS=6 exercises the out-of-range coefficient address guard,
// which a 3-bit address cannot reach when TAPS=8.
// Q1.12 coefficients in 13 bits top out at 4095, so "unity" is 4095.
`timescale 1ns/1ps

module tb_fir_mac_seq;

    logic                CLK = 1'b0;
    logic                RST_n;
    logic                VIN;
    logic signed [12:0]  tp [0:7];
    logic                COEF_WE;
    logic [2:0]          COEF_ADDR;
    logic signed [12:0]  COEF_DIN;
    logic signed [15:0]  DOUT;
    logic                VOUT, BUSY, DROP, OVF;

    logic                vin6, we6;
    logic [2:0]          addr6;
    logic signed [12:0]  din6;
    logic signed [12:0]  tp6 [0:5];
    logic signed [15:0]  dout6;
    logic                vout6, busy6, drop6, ovf6;

    typedef struct {
        logic signed [15:0] dout;
        logic               ovf;
        int                 cyc;
    } exp_t;

    exp_t               sb_q [$];
    exp_t               mon_e;
    logic signed [12:0] m_coef [0:7];
    logic               m_ovf;
    int                 n_vec = 0;
    int                 n_err = 0;
    int                 cyc = 0;
    int                 vout_cnt = 0;
    int                 c0;
    int                 n6;
    logic signed [15:0] md;
    logic               mc;

    fir_mac_seq u_dut (
        .CLK(CLK), .RST_n(RST_n), .VIN(VIN), .tp(tp),
        .COEF_WE(COEF_WE), .COEF_ADDR(COEF_ADDR), .COEF_DIN(COEF_DIN),
        .DOUT(DOUT), .VOUT(VOUT), .BUSY(BUSY), .DROP(DROP), .OVF(OVF)
    );

    fir_mac_seq #(.TAPS(6)) u_dut6 (
        .CLK(CLK), .RST_n(RST_n), .VIN(vin6), .tp(tp6),
        .COEF_WE(we6), .COEF_ADDR(addr6), .COEF_DIN(din6),
        .DOUT(dout6), .VOUT(vout6), .BUSY(busy6), .DROP(drop6), .OVF(ovf6)
    );

    // Clock generation
    always #5 CLK = ~CLK;

    // Edge counter used for latency checks
    always @(posedge CLK) cyc <= cyc + 1;

    task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Scoreboard monitor: pops one expectation per VOUT pulse
    always @(negedge CLK) begin
        if (RST_n === 1'b1 && VOUT === 1'b1) begin
            vout_cnt++;
            if (sb_q.size() == 0) begin
                check("unexpected_vout", VOUT, 1'b0);
            end else begin
                mon_e = sb_q.pop_front();
                check("dout", DOUT, mon_e.dout);
                check("ovf", OVF, mon_e.ovf);
                check("latency", cyc, mon_e.cyc);
            end
        end
    end

    // Reference: full-precision sum, round half-up, shift, limit
    function automatic void model(output logic signed [15:0] d, output logic c);
        longint acc;
        longint r;
        acc = 0;
        for (int i = 0; i < 8; i++) acc = acc + longint'(tp[i]) * longint'(m_coef[i]);
        r = (acc + 64'sd2048) >>> 12;
`ifdef FIR_MAC_SAT_EN
        if (r > 64'sd32767) begin
            d = 16'sh7fff; c = 1'b1;
        end else if (r < -64'sd32768) begin
            d = 16'sh8000; c = 1'b1;
        end else begin
            d = 16'(r); c = 1'b0;
        end
`else
        d = 16'(r); c = 1'b0;
`endif
    endfunction

    // All tasks start and end just after a falling edge
    task automatic wr_coef(input logic [2:0] a, input logic signed [12:0] d);
        COEF_WE = 1'b1; COEF_ADDR = a; COEF_DIN = d;
        m_coef[a] = d;
        @(negedge CLK);
        COEF_WE = 1'b0;
    endtask

    task automatic send_exp(input logic we, input logic [2:0] a, input logic signed [12:0] d,
                            input logic signed [15:0] exp_d, input logic exp_c);
        exp_t e;
        VIN = 1'b1; COEF_WE = we; COEF_ADDR = a; COEF_DIN = d;
        if (we) m_coef[a] = d;
        e.dout = exp_d;
        e.ovf  = m_ovf | exp_c;
        e.cyc  = cyc + 11;
        m_ovf  = m_ovf | exp_c;
        sb_q.push_back(e);
        @(negedge CLK);
        VIN = 1'b0; COEF_WE = 1'b0;
    endtask

    task automatic send_model();
        logic signed [15:0] d;
        logic c;
        model(d, c);
        send_exp(1'b0, 3'd0, 13'sd0, d, c);
    endtask

    task automatic wait_done();
        for (int i = 0; i < 40 && sb_q.size() != 0; i++) @(negedge CLK);
        @(negedge CLK);
        check("result_pending", sb_q.size(), 0);
        sb_q.delete();
    endtask

    // Global time limit
    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Directed stimulus
    initial begin
        VIN = 1'b0; COEF_WE = 1'b0; COEF_ADDR = 3'd0; COEF_DIN = 13'sd0;
        vin6 = 1'b0; we6 = 1'b0; addr6 = 3'd0; din6 = 13'sd0;
        for (int i = 0; i < 8; i++) begin tp[i] = 13'sd0; m_coef[i] = 13'sd0; end
        for (int i = 0; i < 6; i++) tp6[i] = 13'sd0;
        m_ovf = 1'b0;
        RST_n = 1'b0;
        repeat (3) @(negedge CLK);
        check("rst_dout", DOUT, 0);
        check("rst_vout", VOUT, 0);
        check("rst_busy", BUSY, 0);
        check("rst_drop", DROP, 0);
        check("rst_ovf", OVF, 0);
        RST_n = 1'b1;
        @(negedge CLK);

        // Address guard on a 6-tap instance: writes to 6 and 7 must be ignored
        we6 = 1'b1; addr6 = 3'd0; din6 = 13'sd4095;
        @(negedge CLK);
        addr6 = 3'd6;
        @(negedge CLK);
        addr6 = 3'd7;
        @(negedge CLK);
        we6 = 1'b0;
        for (int i = 0; i < 6; i++) tp6[i] = 13'sd10;
        vin6 = 1'b1;
        @(negedge CLK);
        vin6 = 1'b0;
        n6 = 0;
        while (vout6 !== 1'b1 && n6 < 20) begin @(negedge CLK); n6++; end
        check("t6_latency", n6, 8);
        check("t6_dout", dout6, 10);
        @(negedge CLK);
        check("t6_vout_pulse", vout6, 0);
        check("t6_busy", busy6, 0);
        check("t6_drop", drop6, 0);
        check("t6_ovf", ovf6, 0);

        // Impulse: 100 * 4095 rounds to 100
        wr_coef(3'd0, 13'sd4095);
        tp[0] = 13'sd100;
        send_exp(1'b0, 3'd0, 13'sd0, 16'sd100, 1'b0);
        check("busy_after_vin", BUSY, 1);
        wait_done();
        repeat (3) @(negedge CLK);
        check("dout_hold", DOUT, 100);
        check("idle_vout", VOUT, 0);
        check("idle_busy", BUSY, 0);

        // Rounding, coefficient written on the same edge as VIN
        tp[0] = 13'sd3;
        send_exp(1'b1, 3'd0, 13'sd2048, 16'sd2, 1'b0);
        wait_done();
        tp[0] = -13'sd3;
        send_exp(1'b0, 3'd0, 13'sd0, -16'sd1, 1'b0);
        wait_done();

        // Mixed patterns against the reference model
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < 8; i++) wr_coef(3'(i), 13'($urandom_range(8191)));
            for (int i = 0; i < 8; i++) tp[i] = 13'($urandom_range(8191));
            send_model();
            wait_done();
        end

        // Coefficient write while busy must be ignored
        for (int i = 0; i < 8; i++) wr_coef(3'(i), 13'sd0);
        wr_coef(3'd1, 13'sd4095);
        for (int i = 0; i < 8; i++) tp[i] = 13'(i * 37 + 5);
        tp[1] = 13'sd50;
        send_exp(1'b0, 3'd0, 13'sd0, 16'sd50, 1'b0);
        @(negedge CLK);
        COEF_WE = 1'b1; COEF_ADDR = 3'd1; COEF_DIN = 13'sd100;
        @(negedge CLK);
        COEF_WE = 1'b0;
        wait_done();
        send_exp(1'b0, 3'd0, 13'sd0, 16'sd50, 1'b0);
        wait_done();

        // Overrun: second VIN four edges later is dropped
        check("drop_before", DROP, 0);
        send_exp(1'b0, 3'd0, 13'sd0, 16'sd50, 1'b0);
        repeat (3) @(negedge CLK);
        VIN = 1'b1;
        @(negedge CLK);
        VIN = 1'b0;
        check("drop_set", DROP, 1);
        wait_done();
        c0 = vout_cnt;
        repeat (15) @(negedge CLK);
        check("overrun_single_vout", vout_cnt, c0);
        check("drop_sticky", DROP, 1);

        // Full-scale negative taps and coefficients: acc = 2^27
        for (int i = 0; i < 8; i++) wr_coef(3'(i), -13'sd4096);
        for (int i = 0; i < 8; i++) tp[i] = -13'sd4096;
`ifdef FIR_MAC_SAT_EN
        send_exp(1'b0, 3'd0, 13'sd0, 16'sh7fff, 1'b1);
`else
        send_exp(1'b0, 3'd0, 13'sd0, 16'sh8000, 1'b0);
`endif
        wait_done();
        model(md, mc);
        check("model_full_scale", DOUT, md);
        repeat (2) @(negedge CLK);
        check("ovf_sticky", OVF, m_ovf);

        // Reset in the middle of MAC aborts the sample
        for (int i = 0; i < 8; i++) tp[i] = 13'sd0;
        tp[0] = 13'sd100;
        send_model();
        repeat (4) @(negedge CLK);
        RST_n = 1'b0;
        sb_q.delete();
        for (int i = 0; i < 8; i++) m_coef[i] = 13'sd0;
        m_ovf = 1'b0;
        #1;
        check("mid_rst_dout", DOUT, 0);
        check("mid_rst_busy", BUSY, 0);
        check("mid_rst_vout", VOUT, 0);
        check("mid_rst_drop", DROP, 0);
        check("mid_rst_ovf", OVF, 0);
        @(negedge CLK);
        RST_n = 1'b1;
        c0 = vout_cnt;
        repeat (15) @(negedge CLK);
        check("no_vout_after_reset", vout_cnt, c0);
        send_exp(1'b0, 3'd0, 13'sd0, 16'sd0, 1'b0);
        wait_done();
        check("post_reset_vouts", vout_cnt, c0 + 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
